// File: rtl/ram.sv
// ---------------------------------------------------------------------------
// ram: simple-dual-port synchronous RAM, one write port and one read port on
// a single clock. Per-lane storage primitive for on-chip buffers.
//
// Parameters
//   ADDR_WIDTH : address width, depth = 2**ADDR_WIDTH words
//   DATA_WIDTH : word width
//   OUTPUT_REG : 0 -> 1-cycle read latency, 1 -> extra output stage (2 cycles)
//   TYPE       : "block" or "distributed", synthesis RAM-style hint only
//
// Ports
//   clk          : clock, rising edge
//   reset        : synchronous, active-high; clears the read pipeline only
//   s_write_req  : write enable
//   s_write_addr : write address
//   s_write_data : write data
//   s_read_req   : read enable
//   s_read_addr  : read address
//   s_read_data  : read data (registered)
// ---------------------------------------------------------------------------
module ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int OUTPUT_REG = 0,
  parameter     TYPE       = "block"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_write_req,
  input  logic [ADDR_WIDTH-1:0] s_write_addr,
  input  logic [DATA_WIDTH-1:0] s_write_data,
  input  logic                  s_read_req,
  input  logic [ADDR_WIDTH-1:0] s_read_addr,
  output logic [DATA_WIDTH-1:0] s_read_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rd_p1;

  // Storage plus first read stage. The array is declared once per style so
  // the attribute carries a literal value the synthesis tool can recognise.
  // Writes ignore reset and contents are never cleared; the non-blocking
  // read samples the pre-write word, which gives read-first collisions.
  generate
    if (TYPE == "distributed") begin : g_dist
      (* ram_style = "distributed" *)
      logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

      always_ff @(posedge clk) begin
        if (s_write_req) mem[s_write_addr] <= s_write_data;
      end

      always_ff @(posedge clk) begin
        if (reset)           rd_p1 <= '0;
        else if (s_read_req) rd_p1 <= mem[s_read_addr];
      end
    end else begin : g_block
      (* ram_style = "block" *)
      logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

      always_ff @(posedge clk) begin
        if (s_write_req) mem[s_write_addr] <= s_write_data;
      end

      always_ff @(posedge clk) begin
        if (reset)           rd_p1 <= '0;
        else if (s_read_req) rd_p1 <= mem[s_read_addr];
      end
    end
  endgenerate

  // Optional second stage: vld_p1 marks that rd_p1 was loaded by a read on
  // the previous edge, so out_p2 only advances when fresh data is present
  // and otherwise holds the last word.
  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic                  vld_p1;
      logic [DATA_WIDTH-1:0] out_p2;

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_p1 <= 1'b0;
          out_p2 <= '0;
        end else begin
          vld_p1 <= s_read_req;
          if (vld_p1) out_p2 <= rd_p1;
        end
      end

      assign s_read_data = out_p2;
    end else begin : g_noreg
      assign s_read_data = rd_p1;
    end
  endgenerate

endmodule

// File: tb/tb_ram.sv
// ---------------------------------------------------------------------------
// tb_ram: self-checking bench for ram. Two instances (OUTPUT_REG=0 and 1)
// share the same stimulus; a behavioural model tracks memory contents and
// the word each read port should present.
// ---------------------------------------------------------------------------
module tb_ram;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int DEPTH = 2 ** AW;

  logic          clk;
  logic          reset;
  logic          s_write_req;
  logic [AW-1:0] s_write_addr;
  logic [DW-1:0] s_write_data;
  logic          s_read_req;
  logic [AW-1:0] s_read_addr;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;

  int n_tests = 0;
  int n_fail  = 0;

  ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(0), .TYPE("block")) u_ram0 (
    .clk          (clk),
    .reset        (reset),
    .s_write_req  (s_write_req),
    .s_write_addr (s_write_addr),
    .s_write_data (s_write_data),
    .s_read_req   (s_read_req),
    .s_read_addr  (s_read_addr),
    .s_read_data  (rdata0)
  );

  ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(1), .TYPE("distributed")) u_ram1 (
    .clk          (clk),
    .reset        (reset),
    .s_write_req  (s_write_req),
    .s_write_addr (s_write_addr),
    .s_write_data (s_write_data),
    .s_read_req   (s_read_req),
    .s_read_addr  (s_read_addr),
    .s_read_data  (rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: memory image, the word the 1-cycle port shows, the
  // word the 2-cycle port shows, and whether a read was accepted last edge.
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] exp0;
  logic [DW-1:0] exp1;
  logic          read_last;

  // Drive one cycle of inputs, take the edge, update the model, then settle
  // 1 time unit after the edge so outputs are sampled away from it.
  task automatic cycle(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rr, input logic [AW-1:0] ra, input logic rst);
    logic [DW-1:0] old_word;
    s_write_req  = wr;
    s_write_addr = wa;
    s_write_data = wd;
    s_read_req   = rr;
    s_read_addr  = ra;
    reset        = rst;
    @(posedge clk);
    old_word = mem_m[ra];
    if (rst) begin
      exp0      = '0;
      exp1      = '0;
      read_last = 1'b0;
    end else begin
      if (read_last) exp1 = exp0;
      if (rr) exp0 = old_word;
      read_last = rr;
    end
    if (wr) mem_m[wa] = wd;
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b1);
    n_tests++;
    if (rdata0 !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_out0: got %h want %h", rdata0, 16'h0000);
    end
    n_tests++;
    if (rdata1 !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_out1: got %h want %h", rdata1, 16'h0000);
    end
  endtask

  task automatic test_basic();
    cycle(1'b1, 4'd3, 16'hBEEF, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 4'd3, 1'b0);
    n_tests++;
    if (rdata0 !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL basic_read0: got %h want %h", rdata0, 16'hBEEF);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      n_tests++;
      if (rdata0 !== 16'hBEEF) begin
        n_fail++;
        $display("FAIL basic_hold0[%0d]: got %h want %h", i, rdata0, 16'hBEEF);
      end
    end
    n_tests++;
    if (rdata1 !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL basic_read1: got %h want %h", rdata1, 16'hBEEF);
    end
  endtask

  task automatic test_latency();
    cycle(1'b1, 4'd0, 16'h1234, 1'b0, '0, 1'b0);
    cycle(1'b1, 4'd15, 16'h5678, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 4'd0, 1'b0);
    n_tests++;
    if (rdata1 !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL lat_first_edge1: got %h want %h", rdata1, 16'hBEEF);
    end
    cycle(1'b0, '0, '0, 1'b1, 4'd15, 1'b0);
    n_tests++;
    if (rdata1 !== 16'h1234) begin
      n_fail++;
      $display("FAIL lat_second_edge1: got %h want %h", rdata1, 16'h1234);
    end
    n_tests++;
    if (rdata0 !== 16'h5678) begin
      n_fail++;
      $display("FAIL lat_stream0: got %h want %h", rdata0, 16'h5678);
    end
    idle();
    n_tests++;
    if (rdata1 !== 16'h5678) begin
      n_fail++;
      $display("FAIL lat_stream1: got %h want %h", rdata1, 16'h5678);
    end
  endtask

  task automatic test_collision();
    cycle(1'b1, 4'd5, 16'h0011, 1'b0, '0, 1'b0);
    cycle(1'b1, 4'd5, 16'h00AA, 1'b1, 4'd5, 1'b0);
    n_tests++;
    if (rdata0 !== 16'h0011) begin
      n_fail++;
      $display("FAIL coll_old0: got %h want %h", rdata0, 16'h0011);
    end
    cycle(1'b0, '0, '0, 1'b1, 4'd5, 1'b0);
    n_tests++;
    if (rdata0 !== 16'h00AA) begin
      n_fail++;
      $display("FAIL coll_new0: got %h want %h", rdata0, 16'h00AA);
    end
    n_tests++;
    if (rdata1 !== 16'h0011) begin
      n_fail++;
      $display("FAIL coll_old1: got %h want %h", rdata1, 16'h0011);
    end
    idle();
    n_tests++;
    if (rdata1 !== 16'h00AA) begin
      n_fail++;
      $display("FAIL coll_new1: got %h want %h", rdata1, 16'h00AA);
    end
  endtask

  task automatic test_reset_retain();
    cycle(1'b1, 4'd7, 16'hCAFE, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 4'd7, 1'b0);
    // Reset edge with a write (kept) and a read (discarded).
    cycle(1'b1, 4'd8, 16'h7777, 1'b1, 4'd7, 1'b1);
    n_tests++;
    if (rdata0 !== 16'h0000 || rdata1 !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_clear: got %h/%h want 0000/0000", rdata0, rdata1);
    end
    idle();
    n_tests++;
    if (rdata1 !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_discard1: got %h want %h", rdata1, 16'h0000);
    end
    cycle(1'b0, '0, '0, 1'b1, 4'd7, 1'b0);
    n_tests++;
    if (rdata0 !== 16'hCAFE) begin
      n_fail++;
      $display("FAIL rst_retain0: got %h want %h", rdata0, 16'hCAFE);
    end
    n_tests++;
    if (rdata1 !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_restart1: got %h want %h", rdata1, 16'h0000);
    end
    cycle(1'b0, '0, '0, 1'b1, 4'd8, 1'b0);
    n_tests++;
    if (rdata1 !== 16'hCAFE) begin
      n_fail++;
      $display("FAIL rst_retain1: got %h want %h", rdata1, 16'hCAFE);
    end
    n_tests++;
    if (rdata0 !== 16'h7777) begin
      n_fail++;
      $display("FAIL rst_write_kept: got %h want %h", rdata0, 16'h7777);
    end
  endtask

  task automatic test_full_range();
    logic [AW-1:0] a;
    logic [DW-1:0] pat;
    for (int i = 0; i < DEPTH; i++) begin
      a = AW'(i);
      cycle(1'b1, a, 16'hA500 | 16'(i), 1'b0, '0, 1'b0);
    end
    // Write to 2 while reading 9: mem[9] must be unaffected.
    cycle(1'b1, 4'd2, 16'hFFFF, 1'b1, 4'd9, 1'b0);
    n_tests++;
    if (rdata0 !== 16'hA509) begin
      n_fail++;
      $display("FAIL indep_read9: got %h want %h", rdata0, 16'hA509);
    end
    for (int i = 0; i < DEPTH; i++) begin
      a = AW'(i);
      pat = (i == 2) ? 16'hFFFF : (16'hA500 | 16'(i));
      cycle(1'b0, '0, '0, 1'b1, a, 1'b0);
      n_tests++;
      if (rdata0 !== pat) begin
        n_fail++;
        $display("FAIL range0[%0d]: got %h want %h", i, rdata0, pat);
      end
    end
    idle();
    n_tests++;
    if (rdata1 !== 16'hA50F) begin
      n_fail++;
      $display("FAIL range1_max: got %h want %h", rdata1, 16'hA50F);
    end
  endtask

  task automatic test_random();
    logic          wr, rr, rst;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    int            bad0, bad1;
    bad0 = 0;
    bad1 = 0;
    for (int i = 0; i < 2000; i++) begin
      wr  = 1'($urandom_range(0, 1));
      rr  = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 63) == 0);
      wa  = AW'($urandom_range(0, DEPTH - 1));
      // Bias toward collisions now and then.
      ra  = ($urandom_range(0, 7) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      wd  = DW'($urandom);
      cycle(wr, wa, wd, rr, ra, rst);
      n_tests++;
      if (rdata0 !== exp0) begin
        n_fail++;
        bad0++;
        if (bad0 <= 5) $display("FAIL rand0 cyc %0d: got %h want %h", i, rdata0, exp0);
      end
      n_tests++;
      if (rdata1 !== exp1) begin
        n_fail++;
        bad1++;
        if (bad1 <= 5) $display("FAIL rand1 cyc %0d: got %h want %h", i, rdata1, exp1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    exp0      = '0;
    exp1      = '0;
    read_last = 1'b0;
    s_write_req  = 1'b0;
    s_write_addr = '0;
    s_write_data = '0;
    s_read_req   = 1'b0;
    s_read_addr  = '0;
    reset        = 1'b1;

    test_reset();
    test_basic();
    test_latency();
    test_collision();
    test_reset_retain();
    test_full_range();
    test_random();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
